// File: rtl/float_pkg.sv
// Shared single-precision definitions for the float_* arithmetic blocks.
package float_pkg;

   localparam int SIGN_W  = 1;
   localparam int EXP_W   = 8;
   localparam int MANT_W  = 23;
   localparam int FLOAT_W = SIGN_W + EXP_W + MANT_W;

   localparam int BIAS = 127;

   localparam logic [FLOAT_W-1:0] QNAN    = 32'h7FC0_0000;
   localparam logic [FLOAT_W-1:0] POS_INF = 32'h7F80_0000;

   // Operation sequence shared by the iterative float units.
   typedef enum logic [2:0] {
      ST_IDLE,
      ST_UNPACK,
      ST_SPECIAL,
      ST_DIVIDE,
      ST_NORMALISE,
      ST_ROUND,
      ST_PACK
   } state_t;

endpackage

// File: rtl/float_div_if.sv
// Request/response bundle of the float divider.
interface float_div_if;
   import float_pkg::*;

   logic               start;
   logic [FLOAT_W-1:0] a;
   logic [FLOAT_W-1:0] b;
   logic [FLOAT_W-1:0] z;
   logic               valid;
   logic               busy;
   logic               dz;

   modport master (output start, a, b, input z, valid, busy, dz);
   modport slave  (input start, a, b, output z, valid, busy, dz);
endinterface

// File: rtl/float_div_mant.sv
// Restoring mantissa divider: one quotient bit per cycle, 27 bits total.
module float_div_mant
   import float_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              start_i,
   input  logic [MANT_W:0]   dividend_i,
   input  logic [MANT_W:0]   divisor_i,
   output logic [26:0]       quotient_o,
   output logic              sticky_o,
   output logic              done_o
);

   // Partial remainder is always below twice the divisor, so 25 bits suffice.
   logic [24:0]     rem_q,    rem_d;
   logic [MANT_W:0] div_q,    div_d;
   logic [26:0]     quo_q,    quo_d;
   logic [4:0]      cnt_q,    cnt_d;
   logic            active_q, active_d;
   logic [25:0]     trial;

   // One restoring step: subtract, keep the result only if it did not borrow.
   always_comb begin
      rem_d    = rem_q;
      div_d    = div_q;
      quo_d    = quo_q;
      cnt_d    = cnt_q;
      active_d = active_q;
      trial    = {1'b0, rem_q} - {2'b00, div_q};
      if (start_i) begin
         rem_d    = {1'b0, dividend_i};
         div_d    = divisor_i;
         quo_d    = '0;
         cnt_d    = '0;
         active_d = 1'b1;
      end else if (active_q) begin
         if (!trial[25]) begin
            quo_d = {quo_q[25:0], 1'b1};
            rem_d = trial[24:0] << 1;
         end else begin
            quo_d = {quo_q[25:0], 1'b0};
            rem_d = rem_q << 1;
         end
         if (cnt_q == 5'd26) begin
            active_d = 1'b0;
         end else begin
            cnt_d = cnt_q + 5'd1;
         end
      end
   end

   // Divider state registers; reset clears operands and counter.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rem_q    <= '0;
         div_q    <= '0;
         quo_q    <= '0;
         cnt_q    <= '0;
         active_q <= 1'b0;
      end else begin
         rem_q    <= rem_d;
         div_q    <= div_d;
         quo_q    <= quo_d;
         cnt_q    <= cnt_d;
         active_q <= active_d;
      end
   end

   // done marks the final iteration so the caller can leave on the same edge.
   assign done_o     = active_q && (cnt_q == 5'd26);
   assign quotient_o = quo_q;
   assign sticky_o   = |rem_q;

endmodule

// File: rtl/float_div.sv
// Iterative IEEE-754 single-precision divider, round to nearest even.
module float_div
   import float_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   float_div_if.slave bus
);

   state_t state_q, state_d;

   logic [FLOAT_W-1:0] a_q,    a_d;
   logic [FLOAT_W-1:0] b_q,    b_d;
   logic               sign_q, sign_d;
   logic signed [9:0]  exp_q,  exp_d;
   logic [MANT_W:0]    ma_q,   ma_d;
   logic [MANT_W:0]    mb_q,   mb_d;
   logic [26:0]        norm_q, norm_d;
   logic [MANT_W-1:0]  frac_q, frac_d;
   logic [FLOAT_W-1:0] res_q,  res_d;
   logic               spec_q, spec_d;
   logic               dzp_q,  dzp_d;
   logic [FLOAT_W-1:0] z_q,    z_d;
   logic               dz_q,   dz_d;
   logic               valid_q, valid_d;
   logic               busy_q,  busy_d;

   logic               accept;
   logic               mant_start;
   logic [26:0]        mant_quot;
   logic               mant_sticky;
   logic               mant_done;

   logic [EXP_W-1:0]   ea, eb;
   logic               a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
   logic               is_special;
   logic [FLOAT_W-1:0] special_res;
   logic               special_dz;

   logic               round_up;
   logic               round_carry;

   // busy covers the valid cycle, so a start there is also ignored.
   assign accept = (state_q == ST_IDLE) && bus.start && !busy_q;

   // Operand classification; denormals (exponent 0) count as zero.
   assign ea     = a_q[30:23];
   assign eb     = b_q[30:23];
   assign a_nan  = (ea == '1) && (a_q[MANT_W-1:0] != '0);
   assign b_nan  = (eb == '1) && (b_q[MANT_W-1:0] != '0);
   assign a_inf  = (ea == '1) && (a_q[MANT_W-1:0] == '0);
   assign b_inf  = (eb == '1) && (b_q[MANT_W-1:0] == '0);
   assign a_zero = (ea == '0);
   assign b_zero = (eb == '0);
   assign is_special = (ea == '1) || (eb == '1) || a_zero || b_zero;

   // Special-operand result, earlier rules take priority.
   always_comb begin
      special_res = QNAN;
      special_dz  = 1'b0;
      if (a_nan || b_nan || (a_inf && b_inf) || (a_zero && b_zero)) begin
         special_res = QNAN;
      end else if (a_inf) begin
         special_res = {sign_q, POS_INF[30:0]};
      end else if (b_inf || a_zero) begin
         special_res = {sign_q, 31'd0};
      end else if (b_zero) begin
         special_res = {sign_q, POS_INF[30:0]};
         special_dz  = 1'b1;
      end
   end

   // Round to nearest even on the normalised 27-bit quotient.
   assign round_up    = norm_q[2] & ((|norm_q[1:0]) | mant_sticky | norm_q[3]);
   assign round_carry = (&norm_q[26:3]) & round_up;

   assign mant_start = (state_q == ST_SPECIAL) && !is_special;

   float_div_mant u_mant (
      .clk        (clk),
      .rst        (rst),
      .start_i    (mant_start),
      .dividend_i (ma_q),
      .divisor_i  (mb_q),
      .quotient_o (mant_quot),
      .sticky_o   (mant_sticky),
      .done_o     (mant_done)
   );

   // FSM state register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state_q <= ST_IDLE;
      else      state_q <= state_d;
   end

   // FSM next-state logic.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:      if (accept) state_d = ST_UNPACK;
         ST_UNPACK:    state_d = ST_SPECIAL;
         ST_SPECIAL:   state_d = is_special ? ST_PACK : ST_DIVIDE;
         ST_DIVIDE:    if (mant_done) state_d = ST_NORMALISE;
         ST_NORMALISE: state_d = ST_ROUND;
         ST_ROUND:     state_d = ST_PACK;
         ST_PACK:      state_d = ST_IDLE;
         default:      state_d = ST_IDLE;
      endcase
   end

   // FSM output / datapath next-state logic.
   always_comb begin
      a_d     = a_q;
      b_d     = b_q;
      sign_d  = sign_q;
      exp_d   = exp_q;
      ma_d    = ma_q;
      mb_d    = mb_q;
      norm_d  = norm_q;
      frac_d  = frac_q;
      res_d   = res_q;
      spec_d  = spec_q;
      dzp_d   = dzp_q;
      z_d     = z_q;
      dz_d    = dz_q;
      valid_d = 1'b0;
      busy_d  = 1'b1;
      case (state_q)
         ST_IDLE: begin
            busy_d = accept;
            if (accept) begin
               a_d = bus.a;
               b_d = bus.b;
            end
         end
         ST_UNPACK: begin
            sign_d = a_q[31] ^ b_q[31];
            exp_d  = $signed({2'b00, ea}) - $signed({2'b00, eb}) + $signed(10'(BIAS));
            ma_d   = {1'b1, a_q[MANT_W-1:0]};
            mb_d   = {1'b1, b_q[MANT_W-1:0]};
            spec_d = 1'b0;
            dzp_d  = 1'b0;
         end
         ST_SPECIAL: begin
            if (is_special) begin
               spec_d = 1'b1;
               res_d  = special_res;
               dzp_d  = special_dz;
            end
         end
         ST_NORMALISE: begin
            if (!mant_quot[26]) begin
               norm_d = {mant_quot[25:0], 1'b0};
               exp_d  = exp_q - 10'sd1;
            end else begin
               norm_d = mant_quot;
            end
         end
         ST_ROUND: begin
            // On carry-out the fraction wraps to zero, i.e. 1.0 at the next exponent.
            frac_d = norm_q[25:3] + {22'd0, round_up};
            if (round_carry) exp_d = exp_q + 10'sd1;
         end
         ST_PACK: begin
            valid_d = 1'b1;
            dz_d    = dzp_q;
            if (spec_q)                z_d = res_q;
            else if (exp_q <= 10'sd0)   z_d = {sign_q, 31'd0};
            else if (exp_q >= 10'sd255) z_d = {sign_q, POS_INF[30:0]};
            else                       z_d = {sign_q, exp_q[7:0], frac_q};
         end
         default: ;
      endcase
   end

   // Datapath and output registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         a_q     <= '0;
         b_q     <= '0;
         sign_q  <= 1'b0;
         exp_q   <= '0;
         ma_q    <= '0;
         mb_q    <= '0;
         norm_q  <= '0;
         frac_q  <= '0;
         res_q   <= '0;
         spec_q  <= 1'b0;
         dzp_q   <= 1'b0;
         z_q     <= '0;
         dz_q    <= 1'b0;
         valid_q <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         a_q     <= a_d;
         b_q     <= b_d;
         sign_q  <= sign_d;
         exp_q   <= exp_d;
         ma_q    <= ma_d;
         mb_q    <= mb_d;
         norm_q  <= norm_d;
         frac_q  <= frac_d;
         res_q   <= res_d;
         spec_q  <= spec_d;
         dzp_q   <= dzp_d;
         z_q     <= z_d;
         dz_q    <= dz_d;
         valid_q <= valid_d;
         busy_q  <= busy_d;
      end
   end

   assign bus.z     = z_q;
   assign bus.valid = valid_q;
   assign bus.busy  = busy_q;
   assign bus.dz    = dz_q;

endmodule

// File: tb/tb_float_div.sv
// Self-checking bench for float_div: directed table, random ops, corner sequences.
module tb_float_div;

   logic clk;
   logic rst;
   int   n_checks;
   int   n_errors;

   float_div_if bus ();

   float_div dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] z;
      logic        dz;
      int          lat;
   } vec_t;

   vec_t vecs [15];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %08h, expected %08h", name, act, exp);
      end
   endtask

   // Reference division from the IEEE rules using exact wide integer arithmetic.
   function automatic logic [32:0] ref_div(input logic [31:0] a, input logic [31:0] b);
      int              ea, eb, e;
      logic            s;
      logic            an, bn, ai, bi, az, bz;
      longint unsigned ma, mb, q, r, drop, low, half, mant;
      logic [7:0]      e8;
      ea = int'(a[30:23]);
      eb = int'(b[30:23]);
      s  = a[31] ^ b[31];
      an = (ea == 255) && (a[22:0] != 23'd0);
      bn = (eb == 255) && (b[22:0] != 23'd0);
      ai = (ea == 255) && (a[22:0] == 23'd0);
      bi = (eb == 255) && (b[22:0] == 23'd0);
      az = (ea == 0);
      bz = (eb == 0);
      if (an || bn)                 return {1'b0, 32'h7FC00000};
      if ((ai && bi) || (az && bz)) return {1'b0, 32'h7FC00000};
      if (ai)                       return {1'b0, s, 31'h7F800000};
      if (bi || az)                 return {1'b0, s, 31'h00000000};
      if (bz)                       return {1'b1, s, 31'h7F800000};
      ma = longint'({1'b1, a[22:0]});
      mb = longint'({1'b1, b[22:0]});
      q  = (ma << 40) / mb;
      r  = (ma << 40) % mb;
      e  = ea - eb + 127;
      if (q >= (64'd1 << 40)) drop = 17;
      else begin
         drop = 16;
         e    = e - 1;
      end
      mant = q >> drop;
      low  = q & ((64'd1 << drop) - 64'd1);
      half = 64'd1 << (drop - 1);
      if (low > half || (low == half && (r != 0 || mant[0]))) mant = mant + 1;
      if (mant == (64'd1 << 24)) begin
         mant = mant >> 1;
         e    = e + 1;
      end
      if (e <= 0)   return {1'b0, s, 31'h00000000};
      if (e >= 255) return {1'b0, s, 31'h7F800000};
      e8 = e[7:0];
      return {1'b0, s, e8, mant[22:0]};
   endfunction

   // One operation: start, wait for valid (bounded), check result, latency, handshake.
   task automatic run_op(input string name, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp_z, input logic exp_dz, input int exp_lat,
                         input int intrude);
      int          lat;
      logic [31:0] z;
      logic        dz;
      @(negedge clk);
      bus.start = 1'b1;
      bus.a     = a;
      bus.b     = b;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      check({name, " busy_after_accept"}, 32'(bus.busy), 32'd1);
      lat = 0;
      z   = '0;
      dz  = 1'b0;
      for (int i = 1; i <= 60; i++) begin
         @(posedge clk);
         #1;
         if (bus.valid) begin
            lat = i;
            z   = bus.z;
            dz  = bus.dz;
            check({name, " busy_with_valid"}, 32'(bus.busy), 32'd1);
            break;
         end
         if (intrude > 0 && i == intrude) begin
            bus.start = 1'b1;
            bus.a     = ~a;
            bus.b     = 32'h3F800000;
         end else begin
            bus.start = 1'b0;
         end
      end
      bus.start = 1'b0;
      check({name, " z"}, z, exp_z);
      check({name, " dz"}, 32'(dz), 32'(exp_dz));
      check({name, " latency"}, 32'(lat), 32'(exp_lat));
      @(posedge clk);
      #1;
      check({name, " valid_one_cycle"}, 32'(bus.valid), 32'd0);
      check({name, " busy_released"}, 32'(bus.busy), 32'd0);
      check({name, " z_held"}, bus.z, exp_z);
      $display("op %s: a=%08h b=%08h z=%08h dz=%0b lat=%0d", name, a, b, z, dz, lat);
   endtask

   logic [31:0] ra, rb;
   logic [32:0] rexp;
   int          rlat;
   int          pulses;

   initial begin
      n_checks  = 0;
      n_errors  = 0;
      rst       = 1'b0;
      bus.start = 1'b0;
      bus.a     = '0;
      bus.b     = '0;

      vecs[0]  = '{32'h3E99999A, 32'h3E99999A, 32'h3F800000, 1'b0, 32};
      vecs[1]  = '{32'h40C00000, 32'h40000000, 32'h40400000, 1'b0, 32};
      vecs[2]  = '{32'hC0C00000, 32'h40000000, 32'hC0400000, 1'b0, 32};
      vecs[3]  = '{32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 1'b0, 32};
      vecs[4]  = '{32'h3F800000, 32'h00000000, 32'h7F800000, 1'b1, 3};
      vecs[5]  = '{32'h00000000, 32'h00000000, 32'h7FC00000, 1'b0, 3};
      vecs[6]  = '{32'h7F7FFFFF, 32'h3F000000, 32'h7F800000, 1'b0, 32};
      vecs[7]  = '{32'h00800000, 32'h40000000, 32'h00000000, 1'b0, 32};
      vecs[8]  = '{32'h7FC00001, 32'h3F800000, 32'h7FC00000, 1'b0, 3};
      vecs[9]  = '{32'h7F800000, 32'h7F800000, 32'h7FC00000, 1'b0, 3};
      vecs[10] = '{32'hFF800000, 32'h3F800000, 32'hFF800000, 1'b0, 3};
      vecs[11] = '{32'h3F800000, 32'hFF800000, 32'h80000000, 1'b0, 3};
      vecs[12] = '{32'h80000000, 32'h3F800000, 32'h80000000, 1'b0, 3};
      vecs[13] = '{32'h00400000, 32'h3F800000, 32'h00000000, 1'b0, 3};
      vecs[14] = '{32'hBF800000, 32'h00000000, 32'hFF800000, 1'b1, 3};

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      check("reset z", bus.z, 32'h0);
      check("reset valid", 32'(bus.valid), 32'd0);
      check("reset busy", 32'(bus.busy), 32'd0);
      check("reset dz", 32'(bus.dz), 32'd0);
      rst = 1'b1;

      // Directed table; the first start lands on the first edge after release
      for (int i = 0; i < 15; i++) begin
         run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].z, vecs[i].dz, vecs[i].lat, 0);
      end

      // Random operands against the reference model
      for (int n = 0; n < 60; n++) begin
         ra = $urandom;
         rb = $urandom;
         ra[30:23] = 8'($urandom_range(64, 190));
         rb[30:23] = 8'($urandom_range(64, 190));
         case ($urandom_range(0, 13))
            0: ra[30:23] = 8'h00;
            1: rb[30:23] = 8'h00;
            2: ra[30:23] = 8'hFF;
            3: rb[30:23] = 8'hFF;
            4: begin ra[30:23] = 8'hFF; ra[22:0] = 23'd0; end
            5: begin ra[30:23] = 8'($urandom_range(200, 254)); rb[30:23] = 8'($urandom_range(1, 60)); end
            6: begin ra[30:23] = 8'($urandom_range(1, 60)); rb[30:23] = 8'($urandom_range(190, 254)); end
            7: rb[22:0] = ra[22:0];
            default: ;
         endcase
         rexp = ref_div(ra, rb);
         rlat = (ra[30:23] == 8'h00 || ra[30:23] == 8'hFF ||
                 rb[30:23] == 8'h00 || rb[30:23] == 8'hFF) ? 3 : 32;
         run_op($sformatf("rand%0d", n), ra, rb, rexp[31:0], rexp[32], rlat, 0);
      end

      // Start while busy must be ignored
      run_op("busy_start", 32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 1'b0, 32, 5);
      pulses = 0;
      repeat (40) begin
         @(posedge clk);
         #1;
         if (bus.valid) pulses++;
      end
      check("busy_start no_extra_valid", 32'(pulses), 32'd0);

      // Reset at cycle 10 of a division
      run_op("pre_reset", 32'h40C00000, 32'h40000000, 32'h40400000, 1'b0, 32, 0);
      @(negedge clk);
      bus.start = 1'b1;
      bus.a     = 32'h3F800000;
      bus.b     = 32'h40400000;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      repeat (10) @(posedge clk);
      #1;
      rst = 1'b0;
      #1;
      check("midreset busy", 32'(bus.busy), 32'd0);
      check("midreset valid", 32'(bus.valid), 32'd0);
      check("midreset z", bus.z, 32'h0);
      check("midreset dz", 32'(bus.dz), 32'd0);
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b1;
      pulses = 0;
      repeat (50) begin
         @(posedge clk);
         #1;
         if (bus.valid) pulses++;
      end
      check("midreset no_valid_after_release", 32'(pulses), 32'd0);
      $display("op midreset: aborted at cycle 10, valid pulses after release=%0d", pulses);
      run_op("post_reset", 32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 1'b0, 32, 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/float_div.md
FLOAT_DIV -- requirements
Module: float_div

Interface
REQ-001 SHALL have port: clk  input  1  rising-edge clock for all state.
REQ-002 SHALL have port: rst  input  1  reset; asynchronous, active-low; one clock, no other clock domains.
REQ-003 SHALL have port: start  input  1  request; sampled only in IDLE.
REQ-004 SHALL have port: a  input  32  IEEE-754 single-precision dividend; captured when start is accepted.
REQ-005 SHALL have port: b  input  32  IEEE-754 single-precision divisor; captured with a.
REQ-006 SHALL have port: z  output  32  quotient a/b; registered; held until the next accepted start.
REQ-007 SHALL have port: valid  output  1  one-cycle pulse when z is updated.
REQ-008 SHALL have port: busy  output  1  high from the cycle after acceptance until valid, inclusive.
REQ-009 SHALL have port: dz  output  1  divide-by-zero flag; set with valid for finite nonzero a and zero b; held with z.

Function
REQ-010 SHALL accept start only in IDLE; start while busy SHALL be ignored, with no effect on the operation in flight.
REQ-011 SHALL sequence states IDLE -> UNPACK -> SPECIAL -> DIVIDE -> NORMALISE -> ROUND -> PACK -> IDLE.
- SPECIAL SHALL branch directly to PACK for special operands.
REQ-012 SHALL give normal-path latency of exactly 32 cycles, counted from the acceptance edge to the edge on which valid rises.
- 1 cycle each for UNPACK, SPECIAL, NORMALISE, ROUND, PACK.
- 27 cycles in DIVIDE.
REQ-013 SHALL give special-path latency of exactly 3 cycles (UNPACK, SPECIAL, PACK).
REQ-014 SHALL perform DIVIDE as a restoring mantissa division, one quotient bit per cycle.
- Operands: 24-bit mantissas with implicit 1.
- Quotient: 25 quotient bits + guard + round bits; sticky = OR of the nonzero final remainder.
- Iteration counter: 5 bits, counting 0..26.
REQ-015 SHALL compute the exponent as ea - eb + 127, in a 10-bit signed intermediate; NORMALISE SHALL shift left by 1 and decrement the exponent when the quotient MSB is 0.
REQ-016 SHALL round to nearest, ties to even; a mantissa carry-out from rounding SHALL increment the exponent.
REQ-017 SHALL set sign = sign(a) XOR sign(b) for every result except NaN.
REQ-018 SHALL flush denormal inputs to zero of the same sign.
- A result exponent <= 0 SHALL produce signed zero.
- A result exponent >= 255 SHALL produce signed infinity.
REQ-019 SHALL treat these operands as special:
- NaN operand -> 0x7FC00000.
- 0/0 -> 0x7FC00000.
- inf/inf -> 0x7FC00000.
- inf/x -> signed inf.
- x/inf -> signed zero.
- 0/x -> signed zero.
- x/0 -> signed inf with dz=1.
REQ-020 SHALL, when reset is asserted mid-operation, abort immediately to IDLE; no valid pulse SHALL follow reset release without a new start.

Reset
REQ-021 SHALL drive, while rst is low: state=IDLE, z=0x00000000, valid=0, busy=0, dz=0, iteration counter=0, internal operand registers=0.
REQ-022 SHALL accept start on the first rising clk edge after rst deasserts.

Structure
REQ-023 SHALL place the following in shared package float_pkg, for reuse by float_multi and future float blocks:
- field widths (sign 1, exponent 8, mantissa 23);
- BIAS=127;
- QNAN=0x7FC00000;
- POS_INF=0x7F800000;
- the state enumeration.
REQ-024 SHALL implement the iterative restoring divider as sub-module float_div_mant.
- Interface: start, 24-bit dividend/divisor, 27-bit quotient, sticky, done.
- The FSM, special-case decode, normalisation, rounding and packing SHALL stay in float_div.

Verification
REQ-025 SHALL test 0x3E99999A / 0x3E99999A -> z=0x3F800000, dz=0, valid exactly 32 cycles after acceptance.
REQ-026 SHALL test the following, checking sign handling and round-to-nearest-even:
- 0x40C00000 / 0x40000000 -> 0x40400000.
- 0xC0C00000 / 0x40000000 -> 0xC0400000.
- 0x3F800000 / 0x40400000 -> 0x3EAAAAAB.
REQ-027 SHALL test the following, each with valid 3 cycles after acceptance:
- 0x3F800000 / 0x00000000 -> 0x7F800000 with dz=1.
- 0x00000000 / 0x00000000 -> 0x7FC00000 with dz=0.
REQ-028 SHALL test 0x7F7FFFFF / 0x3F000000 -> 0x7F800000 (overflow), and 0x00800000 / 0x40000000 -> 0x00000000 (underflow flush).
REQ-029 SHALL test back-to-back operation:
- a second start asserted while busy SHALL be ignored;
- rst pulled low at cycle 10 of a division SHALL give busy=0, valid=0, z=0 immediately, and no valid pulse after release.
